// File: rtl/clock_divider_multi_if.sv
// ---------------------------------------------------------------------------
// clock_divider_multi_if
//
// Bundles the control and output signals of clock_divider_multi.
// clkin and rst are not part of the bundle; they stay plain module ports.
//
// Parameters
//   N_CH   number of divider channels
//   CNT_W  divisor / counter width
//   CH_W   channel-select width, derived from N_CH (not meant to be overridden)
//
// Signals
//   en           per-channel run enable
//   sync         one-cycle strobe that realigns every running channel
//   wr_en        divisor write strobe
//   wr_ch        target channel of a divisor write
//   wr_div       new divisor value
//   clk_out      divided square wave per channel
//   tick         one-cycle pulse per period per channel
//   upd_pending  channel holds a written divisor that is not yet in use
//
// Modports
//   master  drives the controls and observes the outputs (system side)
//   slave   the divider itself
// ---------------------------------------------------------------------------
interface clock_divider_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 26
) ();
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  en;
    logic             sync;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  upd_pending;

    modport master (
        output en,
        output sync,
        output wr_en,
        output wr_ch,
        output wr_div,
        input  clk_out,
        input  tick,
        input  upd_pending
    );

    modport slave (
        input  en,
        input  sync,
        input  wr_en,
        input  wr_ch,
        input  wr_div,
        output clk_out,
        output tick,
        output upd_pending
    );
endinterface

// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//
// N_CH independent programmable clock dividers running off clkin. Each
// channel produces a registered square wave (clk_out) and a registered
// one-cycle strobe (tick) once per period. Divisor writes land in a shadow
// register and are promoted to the active divisor only at the channel's
// next wrap (or on the next edge while the channel is idle), so a running
// output never sees a truncated or stretched period.
//
// Parameters
//   N_CH         number of channels (1..16)
//   CNT_W        counter / divisor width
//   DEFAULT_DIV  divisor loaded into every channel at reset
//
// Ports
//   clkin  system clock, all logic on the rising edge
//   rst    asynchronous active-high reset
//   bus    clock_divider_multi_if.slave
//            en[N_CH]           per-channel run enable
//            sync               realign all running channels to cnt=0
//            wr_en/wr_ch/wr_div divisor write port (wr_ch >= N_CH ignored)
//            clk_out[N_CH]      divided square waves
//            tick[N_CH]         one-cycle period strobes
//            upd_pending[N_CH]  written divisor not yet applied
//
// The interface instance must be built with the same N_CH and CNT_W.
// ---------------------------------------------------------------------------
module clock_divider_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50_000
) (
    input  logic                  clkin,
    input  logic                  rst,
    clock_divider_multi_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [N_CH-1:0] clk_out_vec;
    logic [N_CH-1:0] tick_vec;
    logic [N_CH-1:0] pend_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] div_act_reg;
            logic [CNT_W-1:0] div_act_next;
            logic [CNT_W-1:0] div_shd_reg;
            logic [CNT_W-1:0] div_shd_next;
            logic             pend_reg;
            logic             pend_next;
            logic             clk_out_reg;
            logic             clk_out_next;
            logic             tick_reg;
            logic             tick_next;

            logic             wr_hit;
            logic             running;
            logic             wrap;
            logic             apply;

            always_comb begin
                // Out-of-range channel numbers never match any gi, so such
                // writes fall through with no effect.
                wr_hit  = bus.wr_en && (bus.wr_ch == CH_W'(gi));
                // A zero divisor parks the channel exactly like en=0.
                running = bus.en[gi] && (div_act_reg != '0);
                wrap    = (cnt_reg == div_act_reg - CNT_W'(1));

                cnt_next     = '0;
                tick_next    = 1'b0;
                clk_out_next = 1'b0;
                apply        = 1'b0;

                if (running) begin
                    // sync forces the realign state and deliberately skips
                    // the wrap path, so no tick and no divisor promotion.
                    if (!bus.sync) begin
                        // Square wave from the pre-edge count: low for
                        // floor(D/2) cycles, high for ceil(D/2).
                        clk_out_next = (cnt_reg >= (div_act_reg >> 1));
                        if (wrap) begin
                            tick_next = 1'b1;
                            apply     = pend_reg;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end else begin
                    // Idle: nothing is being generated, so a pending divisor
                    // can be taken immediately.
                    apply = pend_reg;
                end

                // Promotion reads the pre-edge shadow; a write on the same
                // edge is kept in the shadow and stays pending.
                div_act_next = apply ? div_shd_reg : div_act_reg;
                div_shd_next = wr_hit ? bus.wr_div : div_shd_reg;
                if (wr_hit) begin
                    pend_next = 1'b1;
                end else if (apply) begin
                    pend_next = 1'b0;
                end else begin
                    pend_next = pend_reg;
                end
            end

            always_ff @(posedge clkin or posedge rst) begin
                if (rst) begin
                    cnt_reg     <= '0;
                    div_act_reg <= DIV_RST;
                    div_shd_reg <= DIV_RST;
                    pend_reg    <= 1'b0;
                    clk_out_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    div_act_reg <= div_act_next;
                    div_shd_reg <= div_shd_next;
                    pend_reg    <= pend_next;
                    clk_out_reg <= clk_out_next;
                    tick_reg    <= tick_next;
                end
            end

            assign clk_out_vec[gi] = clk_out_reg;
            assign tick_vec[gi]    = tick_reg;
            assign pend_vec[gi]    = pend_reg;
        end
    endgenerate

    // Every output is straight from a flop; no input reaches them
    // combinationally.
    assign bus.clk_out     = clk_out_vec;
    assign bus.tick        = tick_vec;
    assign bus.upd_pending = pend_vec;

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel clock divider producing N_CH independent divided square waves and matching one-cycle tick strobes from the 50 MHz board clock. Each channel's divide ratio is programmable at runtime through a write port, with glitch-free update at the channel's next wrap. Channels can be enabled individually and phase-aligned with a sync strobe. It supplies the LED, scan and debounce timing in the design.

## Interface
- N_CH, 4, number of divider channels (1..16)
- CNT_W, 26, counter and divisor width in bits
- DEFAULT_DIV, 50_000, divisor loaded into every channel at reset (1 kHz at 50 MHz)
- CH_W, max(1, clog2(N_CH)), derived channel-select width, not overridden
- clkin  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- en  in  N_CH  per-channel run enable, sampled each edge
- sync  in  1  one-cycle strobe, realigns all enabled channel counters
- wr_en  in  1  divisor write strobe
- wr_ch  in  CH_W  target channel of write
- wr_div  in  CNT_W  new divisor value
- clk_out  out  N_CH  divided square wave per channel, registered
- tick  out  N_CH  one-cycle pulse per period per channel, registered
- upd_pending  out  N_CH  channel has a written divisor not yet applied

## Operation
- Per-channel state: cnt (CNT_W), div_act (CNT_W), div_shd (CNT_W), pend (1).
- Reset: cnt=0, div_act=div_shd=DEFAULT_DIV, pend=0; clk_out=0, tick=0, upd_pending=0.
- Write: wr_en with wr_ch<N_CH sets div_shd<=wr_div, pend<=1. wr_ch>=N_CH is ignored, no state change.
- Channel running when en[i]=1 and div_act!=0. Each edge while running:
  - if cnt==div_act-1 (wrap): cnt<=0, tick<=1; if pend, div_act<=div_shd and pend<=0.
  - else: cnt<=cnt+1, tick<=0.
  - clk_out<=(cnt >= div_act>>1), using pre-edge cnt and div_act.
- Channel idle (en[i]=0 or div_act==0): cnt<=0, tick<=0, clk_out<=0; if pend, div_act<=div_shd and pend<=0 on that edge.
- Write on the same edge as a wrap or idle apply: the apply uses the old div_shd; new value is stored and pend stays 1 for the next wrap.
- sync=1: every running channel sets cnt<=0, tick<=0, clk_out<=0; pend is not applied. sync overrides wrap on that edge.
- div_act==1: cnt stays 0, tick=1 every cycle, clk_out=1 constantly.
- Odd divisor D: clk_out low for floor(D/2) cycles, high for ceil(D/2).
- Unsigned arithmetic; cnt never exceeds div_act-1, no overflow path.
- upd_pending[i]=pend[i].

## Timing
- Outputs lag cnt by one cycle; both clk_out and tick are flops, with no combinational path from any input.
- Divisor D running from cnt=0 at edge E0: clk_out rises after edge E0+floor(D/2) and falls after E0+D. tick is high during the cycle after edge E0+D-1, which coincides with the last high cycle of clk_out.
- en rise: first edge with en=1 starts counting from cnt=0. en fall: outputs low one edge later.
- Write-to-effect latency: the new divisor first governs the period that starts after the current wrap. Idle channel: the new divisor applies on the edge after the write.
- rst asserted mid-period: all outputs low immediately (asynchronous), and divisors return to DEFAULT_DIV.

## Test plan
- Reset release, en=1 on ch0 with DEFAULT_DIV overridden to 4 -> clk_out[0] pattern 0,0,1,1 repeating; tick[0] one cycle per 4 cycles, aligned to second high cycle.
- ch1 running at div 4, write div 6 mid-period -> upd_pending[1]=1 until the wrap; current period stays 4, next periods are 6 (3 low/3 high); pending clears on the wrap edge.
- ch2 div 5 -> clk_out 2 low/3 high; write div 1 -> after the wrap, tick=1 and clk_out=1 every cycle; write div 0 -> outputs held 0.
- ch0 div 4 and ch1 div 6 running, pulse sync -> both cnt=0, outputs 0 next cycle, then both restart in phase; no tick on the sync edge.
- Write with wr_ch=N_CH (N_CH=4 → wr_ch=4 not representable, use N_CH=3, wr_ch=3) -> no channel divisor or pending changes.
- Assert rst while ch0 is mid-period with a pending write -> clk_out, tick and upd_pending are 0 immediately; after release, period equals DEFAULT_DIV.
